// File: rtl/ahb_sram_arbiter_if.sv
// Requester and AHB-Lite signal bundle for the two-port SRAM arbiter.
// Latency: none, wiring only.
// Backpressure: reqN_ready and HREADY are the flow-control returns carried here.
interface ahb_sram_arbiter_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
);
    // Requester 0
    logic              req0_valid;
    logic              req0_ready;
    logic              req0_write;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              rsp0_valid;
    logic [DATA_W-1:0] rsp0_rdata;
    logic              rsp0_err;

    // Requester 1
    logic              req1_valid;
    logic              req1_ready;
    logic              req1_write;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              rsp1_valid;
    logic [DATA_W-1:0] rsp1_rdata;
    logic              rsp1_err;

    // AHB-Lite master side towards the SRAM slave
    logic              HSEL;
    logic [ADDR_W-1:0] HADDR;
    logic              HWRITE;
    logic [1:0]        HTRANS;
    logic [2:0]        HSIZE;
    logic [DATA_W-1:0] HWDATA;
    logic [DATA_W-1:0] HRDATA;
    logic              HREADY;
    logic              HRESP;

    // Arbiter view: takes requests and slave responses, drives grants, responses and the bus.
    modport slave (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        output req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        output req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
        output HSEL, HADDR, HWRITE, HTRANS, HSIZE, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    // Environment view: the requesters plus the AHB slave sitting around the arbiter.
    modport master (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        input  req0_ready, rsp0_valid, rsp0_rdata, rsp0_err,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        input  req1_ready, rsp1_valid, rsp1_rdata, rsp1_err,
        input  HSEL, HADDR, HWRITE, HTRANS, HSIZE, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb_sram_arbiter.sv
// Round-robin arbiter of two requesters onto a single AHB-Lite SRAM port, one transfer in flight.
// Latency: accept cycle 0, address phase 1, data phase 2, rspN_valid at 3 (plus HREADY wait states).
// Backpressure: reqN_ready only in IDLE; HREADY low stretches the address or data phase.
module ahb_sram_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESETn,
    ahb_sram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;

    // Arbitration
    logic              req_any;
    logic              gnt_sel;
    logic              accept;
    logic              last_gnt;

    // Transfer captured at acceptance; requester inputs are ignored afterwards
    logic              cap_id;
    logic              cap_write;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    logic [DATA_W-1:0] hwdata_q;

    // Per-requester response registers
    logic              rsp0_valid_q;
    logic              rsp1_valid_q;
    logic [DATA_W-1:0] rsp0_rdata_q;
    logic [DATA_W-1:0] rsp1_rdata_q;
    logic              rsp0_err_q;
    logic              rsp1_err_q;

    logic              addr_done;
    logic              data_done;

    assign addr_done = (state == ADDR) && bus.HREADY;
    assign data_done = (state == DATA) && bus.HREADY;

    // Round-robin pick: a lone requester wins, under contention the one not granted last wins.
    always_comb begin
        req_any = bus.req0_valid | bus.req1_valid;
        gnt_sel = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            gnt_sel = ~last_gnt;
        end else if (bus.req1_valid) begin
            gnt_sel = 1'b1;
        end
        // Reset gating keeps ready low while HRESETn is asserted.
        accept = (state == IDLE) && req_any && HRESETn;
    end

    // State register.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: accept -> ADDR, HREADY advances ADDR -> DATA -> IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept)    state_nxt = ADDR;
            ADDR:    if (addr_done) state_nxt = DATA;
            DATA:    if (data_done) state_nxt = IDLE;
            default:                state_nxt = IDLE;
        endcase
    end

    // Output logic: AHB control per phase and the one-cycle grant strobe.
    always_comb begin
        bus.HSEL       = 1'b0;
        bus.HTRANS     = 2'b00;
        bus.HSIZE      = 3'b000;
        bus.HADDR      = '0;
        bus.HWRITE     = 1'b0;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        case (state)
            IDLE: begin
                bus.req0_ready = accept && !gnt_sel;
                bus.req1_ready = accept &&  gnt_sel;
            end
            ADDR: begin
                bus.HSEL   = 1'b1;
                bus.HTRANS = 2'b10;
                bus.HSIZE  = 3'b010;
                bus.HADDR  = cap_addr;
                bus.HWRITE = cap_write;
            end
            default: begin
            end
        endcase
    end

    // Capture the granted request and remember who won for the next contention.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            cap_id    <= 1'b0;
            cap_write <= 1'b0;
            cap_addr  <= '0;
            cap_wdata <= '0;
            last_gnt  <= 1'b1;
        end else if (accept) begin
            cap_id    <= gnt_sel;
            cap_write <= gnt_sel ? bus.req1_write : bus.req0_write;
            cap_addr  <= gnt_sel ? bus.req1_addr  : bus.req0_addr;
            cap_wdata <= gnt_sel ? bus.req1_wdata : bus.req0_wdata;
            last_gnt  <= gnt_sel;
        end
    end

    // Write data enters the bus with the data phase and then lingers until the next transfer.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            hwdata_q <= '0;
        end else if (addr_done) begin
            hwdata_q <= cap_wdata;
        end
    end

    // Completion: latch read data / error for the owner and pulse its valid for one cycle.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= '0;
            rsp1_rdata_q <= '0;
            rsp0_err_q   <= 1'b0;
            rsp1_err_q   <= 1'b0;
        end else begin
            rsp0_valid_q <= data_done && !cap_id;
            rsp1_valid_q <= data_done &&  cap_id;
            if (data_done && !cap_id) begin
                rsp0_rdata_q <= cap_write ? '0 : bus.HRDATA;
                rsp0_err_q   <= bus.HRESP;
            end
            if (data_done && cap_id) begin
                rsp1_rdata_q <= cap_write ? '0 : bus.HRDATA;
                rsp1_err_q   <= bus.HRESP;
            end
        end
    end

    assign bus.HWDATA     = hwdata_q;
    assign bus.rsp0_valid = rsp0_valid_q;
    assign bus.rsp1_valid = rsp1_valid_q;
    assign bus.rsp0_rdata = rsp0_rdata_q;
    assign bus.rsp1_rdata = rsp1_rdata_q;
    assign bus.rsp0_err   = rsp0_err_q;
    assign bus.rsp1_err   = rsp1_err_q;

endmodule

// File: tb/tb_ahb_sram_arbiter.sv
// Bench for the two-port AHB SRAM arbiter: directed scenarios then randomized traffic.
// Latency: a transaction-level model predicts grants, bus phases and completion timing.
// Backpressure: random HREADY wait states and random HRESP from a small SRAM slave model.
module tb_ahb_sram_arbiter;
    localparam int AW = 4;
    localparam int DW = 32;

    logic HCLK = 1'b0;
    logic HRESETn;
    always #5 HCLK = ~HCLK;

    ahb_sram_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ahb_sram_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ---------------- AHB SRAM slave ----------------
    bit [DW-1:0]   smem [16];
    bit            dp_vld;
    bit            dp_write;
    logic [AW-1:0] dp_addr;

    // Decisions made at negedge describe what the coming rising edge does.
    always @(negedge HCLK) begin
        if (!HRESETn) begin
            dp_vld = 1'b0;
        end else if (bus.HREADY) begin
            if (dp_vld && dp_write && !bus.HRESP) smem[dp_addr] = bus.HWDATA;
            dp_vld   = bus.HSEL && (bus.HTRANS == 2'b10);
            dp_addr  = bus.HADDR;
            dp_write = bus.HWRITE;
        end
        @(posedge HCLK);
        #1;
        bus.HRDATA = (dp_vld && !dp_write) ? smem[dp_addr] : DW'($urandom);
    end

    // ---------------- reference model ----------------
    bit [DW-1:0]   m_mem [16];
    bit            m_busy;
    int            m_edges;      // HREADY-high edges seen since acceptance
    bit            m_who;
    bit            m_last;
    logic          m_write;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    bit            m_rsp_due;
    bit            m_rsp_who;
    logic [DW-1:0] m_rdata [2];
    logic          m_err   [2];

    always @(negedge HCLK) begin
        if (!HRESETn) begin
            check("rst_req0_ready", bus.req0_ready, 0);
            check("rst_req1_ready", bus.req1_ready, 0);
            check("rst_rsp0_valid", bus.rsp0_valid, 0);
            check("rst_rsp1_valid", bus.rsp1_valid, 0);
            check("rst_rsp0_rdata", bus.rsp0_rdata, 0);
            check("rst_rsp1_rdata", bus.rsp1_rdata, 0);
            check("rst_rsp_err", {bus.rsp1_err, bus.rsp0_err}, 0);
            check("rst_hsel", bus.HSEL, 0);
            check("rst_htrans", bus.HTRANS, 0);
            check("rst_hsize", bus.HSIZE, 0);
            check("rst_haddr", bus.HADDR, 0);
            check("rst_hwrite", bus.HWRITE, 0);
            check("rst_hwdata", bus.HWDATA, 0);
            m_busy = 0; m_edges = 0; m_last = 1; m_rsp_due = 0;
            m_rdata[0] = '0; m_rdata[1] = '0; m_err[0] = 0; m_err[1] = 0;
        end else begin
            check("rsp0_valid", bus.rsp0_valid, m_rsp_due && !m_rsp_who);
            check("rsp1_valid", bus.rsp1_valid, m_rsp_due &&  m_rsp_who);
            check("rsp0_rdata", bus.rsp0_rdata, m_rdata[0]);
            check("rsp1_rdata", bus.rsp1_rdata, m_rdata[1]);
            check("rsp0_err", bus.rsp0_err, m_err[0]);
            check("rsp1_err", bus.rsp1_err, m_err[1]);
            m_rsp_due = 0;
            if (!m_busy) begin
                bit acc, who;
                acc = bus.req0_valid || bus.req1_valid;
                if (bus.req0_valid && bus.req1_valid) who = !m_last;
                else                                  who = bus.req1_valid;
                check("req0_ready", bus.req0_ready, acc && !who);
                check("req1_ready", bus.req1_ready, acc &&  who);
                check("idle_bus", {bus.HSEL, bus.HTRANS, bus.HWRITE, bus.HADDR}, 0);
                if (acc) begin
                    m_busy = 1; m_edges = 0; m_who = who; m_last = who;
                    m_write = who ? bus.req1_write : bus.req0_write;
                    m_addr  = who ? bus.req1_addr  : bus.req0_addr;
                    m_wdata = who ? bus.req1_wdata : bus.req0_wdata;
                end
            end else begin
                check("busy_ready", {bus.req1_ready, bus.req0_ready}, 0);
                if (m_edges == 0) begin
                    check("addr_ctl", {bus.HSEL, bus.HTRANS, bus.HSIZE}, {1'b1, 2'b10, 3'b010});
                    check("addr_haddr", bus.HADDR, m_addr);
                    check("addr_hwrite", bus.HWRITE, m_write);
                end else begin
                    check("data_bus", {bus.HSEL, bus.HTRANS, bus.HWRITE, bus.HADDR}, 0);
                    check("data_hwdata", bus.HWDATA, m_wdata);
                end
                if (bus.HREADY) begin
                    m_edges++;
                    if (m_edges == 2) begin
                        m_rdata[m_who] = m_write ? '0 : m_mem[m_addr];
                        m_err[m_who]   = bus.HRESP;
                        if (m_write && !bus.HRESP) m_mem[m_addr] = m_wdata;
                        m_rsp_due = 1; m_rsp_who = m_who; m_busy = 0;
                    end
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic drive_idle();
        bus.req0_valid = 0; bus.req0_write = 0; bus.req0_addr = '0; bus.req0_wdata = '0;
        bus.req1_valid = 0; bus.req1_write = 0; bus.req1_addr = '0; bus.req1_wdata = '0;
        bus.HREADY = 1; bus.HRESP = 0;
    endtask

    task automatic set_req(input bit id, input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (id) begin
            bus.req1_valid = 1; bus.req1_write = wr; bus.req1_addr = a; bus.req1_wdata = d;
        end else begin
            bus.req0_valid = 1; bus.req0_write = wr; bus.req0_addr = a; bus.req0_wdata = d;
        end
    endtask

    task automatic apply_reset();
        HRESETn = 0;
        repeat (2) tick();
        HRESETn = 1;
    endtask

    initial begin
        HRESETn = 0;
        bus.HRDATA = '0;
        drive_idle();
        repeat (3) tick();
        HRESETn = 1;

        // Write then read; the read is accepted in the write's response cycle.
        set_req(0, 1, 4'd1, 32'hABCD1234);
        tick();
        drive_idle();
        tick(); tick();
        set_req(1, 0, 4'd1, 32'h0);
        @(negedge HCLK);
        check("wr_rsp0_cycle3", bus.rsp0_valid, 1);
        check("rd_accept_same_cycle", bus.req1_ready, 1);
        tick();
        drive_idle();
        tick(); tick();
        @(negedge HCLK);
        check("rd_rsp1_cycle3", bus.rsp1_valid, 1);
        check("rd_rsp1_rdata", bus.rsp1_rdata, 32'hABCD1234);
        check("rd_rsp1_err", bus.rsp1_err, 0);

        // Contention right after reset: req0 first, then req1 on the next contention.
        tick();
        apply_reset();
        set_req(0, 1, 4'd2, 32'h22220000);
        set_req(1, 1, 4'd3, 32'h33330000);
        @(negedge HCLK);
        check("cont1_req0", bus.req0_ready, 1);
        check("cont1_req1", bus.req1_ready, 0);
        tick(); tick(); tick();
        @(negedge HCLK);
        check("cont2_req1", bus.req1_ready, 1);
        check("cont2_req0", bus.req0_ready, 0);
        tick();
        bus.req1_valid = 0;
        tick(); tick();
        @(negedge HCLK);
        check("cont_rsp1", bus.rsp1_valid, 1);
        check("cont3_req0", bus.req0_ready, 1);
        tick();
        drive_idle();
        repeat (4) tick();

        // Three data-phase wait states.
        set_req(0, 1, 4'd5, 32'h5555AAAA);
        tick();
        drive_idle();
        tick();
        bus.HREADY = 0;
        tick(); tick();
        @(negedge HCLK);
        check("wait_hwdata", bus.HWDATA, 32'h5555AAAA);
        check("wait_no_rsp", bus.rsp0_valid, 0);
        tick();
        bus.HREADY = 1;
        tick();
        @(negedge HCLK);
        check("wait_rsp0", bus.rsp0_valid, 1);
        tick();

        // Error response on a read.
        set_req(1, 0, 4'd5, 32'h0);
        tick();
        drive_idle();
        tick();
        bus.HRESP = 1;
        tick();
        bus.HRESP = 0;
        @(negedge HCLK);
        check("err_rsp1_valid", bus.rsp1_valid, 1);
        check("err_rsp1_err", bus.rsp1_err, 1);
        check("err_rsp1_rdata", bus.rsp1_rdata, 32'h5555AAAA);
        tick();

        // Reset pulse during the data phase.
        set_req(0, 1, 4'd7, 32'h11112222);
        tick();
        drive_idle();
        tick();
        bus.HREADY = 0;
        #1;
        HRESETn = 0;
        @(negedge HCLK);
        check("rstd_hwdata", bus.HWDATA, 0);
        check("rstd_rsp0_rdata", bus.rsp0_rdata, 0);
        tick();
        bus.HREADY = 1;
        tick();
        HRESETn = 1;
        @(negedge HCLK);
        check("rstd_no_rsp", bus.rsp0_valid, 0);
        tick();
        set_req(0, 1, 4'd0, 32'hCDEF9876);
        tick();
        drive_idle();
        tick(); tick();
        @(negedge HCLK);
        check("post_rst_rsp0", bus.rsp0_valid, 1);
        tick();
        set_req(1, 0, 4'd0, 32'h0);
        tick();
        drive_idle();
        tick(); tick();
        @(negedge HCLK);
        check("post_rst_rdata", bus.rsp1_rdata, 32'hCDEF9876);
        tick();

        // Randomized traffic with wait states, errors and occasional reset pulses.
        for (int i = 0; i < 3000; i++) begin
            bus.req0_valid = ($urandom_range(0, 1) == 0);
            bus.req0_write = 1'($urandom);
            bus.req0_addr  = AW'($urandom);
            bus.req0_wdata = DW'($urandom);
            bus.req1_valid = ($urandom_range(0, 1) == 0);
            bus.req1_write = 1'($urandom);
            bus.req1_addr  = AW'($urandom);
            bus.req1_wdata = DW'($urandom);
            bus.HREADY     = ($urandom_range(0, 3) != 0);
            bus.HRESP      = ($urandom_range(0, 7) == 0);
            HRESETn        = ($urandom_range(0, 299) != 0);
            tick();
        end
        HRESETn = 1;
        drive_idle();
        repeat (6) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/ahb_sram_arbiter.md
AHB_SRAM_ARBITER -- requirements
Module: ahb_sram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 4, AHB address width in bits.
REQ-002 SHALL have parameter DATA_W, default 32, data width in bits.
REQ-003 SHALL have port HCLK  input  1  clock; all logic is on the rising edge.
REQ-004 SHALL have port HRESETn  input  1  asynchronous active-low reset.
REQ-005 SHALL have port reqN_valid  input  1  requester N (N=0,1) has a transfer pending.
REQ-006 SHALL have port reqN_ready  output  1  requester N transfer accepted this cycle.
REQ-007 SHALL have port reqN_write  input  1  1=write, 0=read.
REQ-008 SHALL have port reqN_addr  input  ADDR_W  word address.
REQ-009 SHALL have port reqN_wdata  input  DATA_W  write data.
REQ-010 SHALL have port rspN_valid  output  1  one-cycle completion pulse to requester N.
REQ-011 SHALL have port rspN_rdata  output  DATA_W  read data, valid with rspN_valid.
REQ-012 SHALL have port rspN_err  output  1  HRESP error seen, valid with rspN_valid.
REQ-013 SHALL have ports HSEL/HADDR/HWRITE/HTRANS[1:0]/HSIZE[2:0]/HWDATA  output  AHB-Lite master signals.
REQ-014 SHALL have ports HRDATA (DATA_W), HREADY (1) and HRESP (1)  input  slave response; HREADY is the slave HREADYOUT.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, ADDR, DATA.
REQ-016 SHALL, in IDLE with any reqN_valid, grant one requester, assert that reqN_ready combinationally for one cycle, capture write/addr/wdata, and go to ADDR.
REQ-017 SHALL arbitrate round-robin: a lone valid requester wins; with both valid, the requester not granted last wins; last-grant resets to 1, so req0 wins first contention.
REQ-018 SHALL, in ADDR, drive HSEL=1, HTRANS=2'b10 (NONSEQ), HSIZE=3'b010, HADDR and HWRITE from the capture, and go to DATA on an edge with HREADY=1; otherwise hold all signals.
REQ-019 SHALL, in DATA, drive HSEL=0, HTRANS=2'b00, HADDR=0, HWRITE=0, HWDATA=captured wdata, and hold until an edge with HREADY=1.
REQ-020 SHALL, on the DATA-completing edge, register HRDATA (reads) or zero (writes) into rspN_rdata and HRESP into rspN_err, pulse rspN_valid for the granted N on the following cycle, and return to IDLE.
REQ-021 SHALL keep one transfer outstanding at most; uncontended latency is accept at cycle 0, ADDR at 1, DATA at 2, rspN_valid at 3 with HREADY=1 throughout.
REQ-022 SHALL allow a new accept in the same IDLE cycle that rspN_valid is high.
REQ-023 SHALL hold rspN_rdata and rspN_err stable until that requester's next completion.
REQ-024 SHALL never assert both reqN_ready or both rspN_valid in one cycle.
REQ-025 SHALL drive HSEL=0, HTRANS=2'b00, HADDR=0 and HWRITE=0 in IDLE; HWDATA keeps its last value.
REQ-026 SHALL ignore reqN_* changes after acceptance; the captured values govern the transfer.

Reset
REQ-027 SHALL, on HRESETn low at any time including mid-transfer, go to IDLE, clear captures, set last-grant=1, and zero every output with no response pulse.
REQ-028 SHALL resume normal arbitration on the first rising HCLK after HRESETn deasserts.

Verification
REQ-029 SHALL pass this write-then-read case: req0 writes 0xABCD1234 to addr 1, then req1 reads addr 1 -> rsp1_rdata=0xABCD1234, rsp1_err=0, each rsp at cycle 3 after accept.
REQ-030 SHALL pass this contention case: req0 and req1 valid in the same cycle after reset -> req0 is served first, then req1; a second contention is served req1 first.
REQ-031 SHALL pass this wait-state case: the slave holds HREADY=0 for 3 cycles in DATA -> HWDATA and the state are held, and rspN_valid comes 3 cycles later.
REQ-032 SHALL pass this error case: HRESP=1 on the completing edge -> rspN_valid=1 with rspN_err=1.
REQ-033 SHALL pass this reset case: HRESETn is pulsed low during DATA -> outputs are zero at once, no rsp pulse, and the next req0 write of 0xCDEF9876 to addr 0 completes normally.
